serial_magnitude_compare_ctrl: RTL and testbench
================================================

Name: serial_magnitude_compare_ctrl

Overview:
Sequencing controller that compares two wide unsigned operands using one shared 4-bit magnitude-compare stage. It walks nibbles from most significant to least significant and stops at the first unequal nibble. It reports less-than, greater-than and equal flags through a start/busy/done handshake. It sits between a requesting datapath and the nibble comparator, so arbitrary-width compares cost only one 4-bit stage.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 1..16.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
a  input  4*NIBBLES  operand A, unsigned; sampled on accepted start
b  input  4*NIBBLES  operand B, unsigned; sampled on accepted start
busy  output  1  high while a compare is in progress (COMPARE or DONE state)
done  output  1  one-cycle pulse when the result is valid
lt  output  1  A < B
gt  output  1  A > B
eq  output  1  A == B

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (asynchronous, any state, including mid-compare):
  - state=IDLE; busy=0, done=0, lt=0, gt=0, eq=0.
  - Operand registers and nibble index cleared.
  - No done pulse for an in-flight compare.
- States:
  - IDLE: busy=0. If start=1, latch a and b into internal registers, set idx=NIBBLES-1, go to COMPARE.
  - COMPARE: busy=1. Compare nibble idx of latched A against nibble idx of latched B.
    - A nibble < B nibble: load lt=1, gt=0, eq=0; go to DONE.
    - A nibble > B nibble: load lt=0, gt=1, eq=0; go to DONE.
    - Nibbles equal and idx==0: load lt=0, gt=0, eq=1; go to DONE.
    - Nibbles equal and idx>0: idx<=idx-1; stay in COMPARE.
  - DONE: busy=1, done=1 for exactly this one cycle; unconditionally go to IDLE.
- Result flags are registered and load on the same edge that enters DONE.
  - They hold their value through IDLE until the next result loads.
  - Exactly one of lt/gt/eq is 1 after the first completed compare; all three are 0 only after reset.
- Latency: start sampled at edge 0. If k nibbles are examined (1 ≤ k ≤ NIBBLES), done is high in the cycle after edge k+1. That gives best case 2 cycles start-to-done and worst case NIBBLES+1.
- start while busy: ignored and not queued; latched operands are unaffected.
- Changes on a/b after the start is accepted: no effect on the running compare.
- start asserted in the cycle after DONE (state IDLE): accepted normally; back-to-back throughput is one compare per k+2 cycles.
- NIBBLES=1: a single COMPARE cycle always terminates.
- idx is sized ceil(log2(NIBBLES)), minimum 1 bit; it never wraps below 0.
- All comparisons are unsigned.

Test Plan:
- Reset mid-compare: NIBBLES=4, start with a=16'h1234, b=16'h1234; assert reset in the second COMPARE cycle -> busy, done, lt, gt, eq all 0 immediately; no done pulse afterwards; next start runs normally.
- Early exit on MSB: a=16'hA000, b=16'h5FFF, start -> gt=1, lt=0, eq=0; done is high in the cycle after edge 2; busy=1 for 2 cycles.
- Full walk, equal: a=b=16'hBEEF -> eq=1; done after 4 COMPARE cycles (cycle after edge 5).
- LSB decides: a=16'h1233, b=16'h1234 -> lt=1 after 4 COMPARE cycles; then start with a=16'hFFFF, b=16'h0000 in the first IDLE cycle -> gt=1, lt=0 two cycles later.
- start ignored while busy: during a=16'h0001, b=16'h0002, pulse start with a=16'hFFFF, b=0 in COMPARE -> result lt=1, only one done pulse.
- Flag hold and NIBBLES=1: a=4'h7, b=4'h7 -> eq=1, done in the cycle after edge 2; eq stays 1 for 10 idle cycles with start=0 and a/b toggling.

Source files
------------

// File: rtl/serial_magnitude_compare_ctrl.sv
// Serial magnitude comparator: walks operand nibbles MSB-first through one
// shared 4-bit compare and stops at the first unequal nibble.
module serial_magnitude_compare_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic                   lt,
  output logic                   gt,
  output logic                   eq
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  a_nxt;
  logic [W-1:0]  b_nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [2:0]    flags;
  logic [2:0]    flags_nxt;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic          nib_lt;
  logic          nib_gt;
  logic          nib_eq;
  logic          last;

  // Operands shift left as nibbles match, so the active nibble is always on top
  assign a_nib  = a_q[W-1 -: 4];
  assign b_nib  = b_q[W-1 -: 4];
  assign nib_lt = (a_nib < b_nib);
  assign nib_gt = (a_nib > b_nib);
  assign nib_eq = (a_nib == b_nib);
  assign last   = (idx == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      flags <= '0;
    end else begin
      state <= state_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      idx   <= idx_nxt;
      flags <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    idx_nxt   = idx;
    flags_nxt = flags;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_nxt     = a;
          b_nxt     = b;
          idx_nxt   = IDX_TOP;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        unique case (1'b1)
          nib_lt: begin
            flags_nxt = 3'b100;
            state_nxt = DONE;
          end
          nib_gt: begin
            flags_nxt = 3'b010;
            state_nxt = DONE;
          end
          (nib_eq && last): begin
            flags_nxt = 3'b001;
            state_nxt = DONE;
          end
          (nib_eq && !last): begin
            idx_nxt = idx - IW'(1);
            a_nxt   = a_q << 4;
            b_nxt   = b_q << 4;
          end
          default: state_nxt = IDLE;
        endcase
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign lt   = flags[2];
  assign gt   = flags[1];
  assign eq   = flags[0];

endmodule

// File: tb/tb_serial_magnitude_compare_ctrl.sv
// Scoreboard bench for serial_magnitude_compare_ctrl: random and directed
// compares at NIBBLES=4, plus a directed NIBBLES=1 instance.
module tb_serial_magnitude_compare_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, lt, gt, eq;

  logic         start1 = 1'b0;
  logic [3:0]   a1 = '0;
  logic [3:0]   b1 = '0;
  logic         busy1, done1, lt1, gt1, eq1;

  serial_magnitude_compare_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .lt(lt), .gt(gt), .eq(eq)
  );

  serial_magnitude_compare_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .lt(lt1), .gt(gt1), .eq(eq1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] fl;
    int         acc;
    int         k;
  } exp_t;

  exp_t       q[$];
  int         next_free = 0;
  bit         cur_valid = 1'b0;
  int         cur_acc = 0;
  int         cur_k = 0;
  logic [2:0] hold = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, expv, cyc);
    end
  endtask

  // Nibbles examined = nibbles from the top down to the one holding the
  // highest differing bit; all of them when the operands are equal.
  function automatic int model_k(input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x ^ y;
    if (d == '0) return N;
    for (int i = W - 1; i >= 0; i--)
      if (d[i]) return N - i / 4;
    return N;
  endfunction

  function automatic logic [2:0] model_fl(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    return {x < y, x > y, x == y};
  endfunction

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   g;
    g = 0;
    while (cyc + 1 < next_free) begin
      if (g > 200) begin
        chk("issue_wait", 0, 1);
        break;
      end
      @(negedge clk);
      g++;
    end
    start = 1'b1;
    a = av;
    b = bv;
    e.fl = model_fl(av, bv);
    e.k = model_k(av, bv);
    e.acc = cyc + 1;
    q.push_back(e);
    cur_valid = 1'b1;
    cur_acc = e.acc;
    cur_k = e.k;
    next_free = e.acc + e.k + 2;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic rand_pair(output logic [W-1:0] av, output logic [W-1:0] bv);
    av = W'($urandom);
    case ($urandom_range(0, 3))
      0: bv = av;
      1: bv = W'($urandom);
      default: bv = av ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
    endcase
  endtask

  // Monitor: pops the scoreboard on every done, tracks busy and flag hold
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk("reset_outs", {busy, done, lt, gt, eq}, 0);
      end else begin
        chk("busy", busy,
            cur_valid && cyc >= cur_acc && cyc <= cur_acc + cur_k);
        if (done) begin
          if (q.size() == 0) begin
            chk("spurious_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc - e.acc, e.k);
            chk("flags", {lt, gt, eq}, e.fl);
            hold = e.fl;
          end
        end else begin
          chk("flag_hold", {lt, gt, eq}, hold);
          if (q.size() > 0 && cyc > q[0].acc + q[0].k + 3) begin
            chk("done_timeout", 0, 1);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   x, y;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, lt, gt, eq}, 0);
    chk("reset_state1", {busy1, done1, lt1, gt1, eq1}, 0);
    reset = 1'b0;
    next_free = cyc + 1;

    issue(16'hA000, 16'h5FFF);
    issue(16'hBEEF, 16'hBEEF);
    issue(16'h1233, 16'h1234);
    issue(16'hFFFF, 16'h0000);

    issue(16'h0001, 16'h0002);
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'h0000;
    @(negedge clk);
    start = 1'b0;

    // Reset in the second COMPARE cycle of an in-flight compare
    issue(16'h1234, 16'h1234);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    cur_valid = 1'b0;
    hold = '0;
    #1;
    chk("reset_mid", {busy, done, lt, gt, eq}, 0);
    @(negedge clk);
    reset = 1'b0;
    next_free = cyc + 1;
    repeat (6) @(negedge clk);
    issue(16'h1234, 16'h1235);

    repeat (250) begin
      if (cyc + 1 >= next_free && $urandom_range(0, 3) != 0) begin
        rand_pair(ra, rb);
        issue(ra, rb);
      end else begin
        if (cyc + 1 < next_free) begin
          start = 1'($urandom_range(0, 1));
          a = W'($urandom);
          b = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    repeat (N + 4) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    start1 = 1'b1;
    a1 = 4'h7;
    b1 = 4'h7;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_busy", {busy1, done1}, 2'b10);
    @(negedge clk);
    chk("n1_done", {busy1, done1}, 2'b11);
    chk("n1_eq", {lt1, gt1, eq1}, 3'b001);
    repeat (10) begin
      a1 = 4'($urandom);
      b1 = 4'($urandom);
      @(negedge clk);
      chk("n1_hold", {busy1, done1, lt1, gt1, eq1}, 5'b00001);
    end
    repeat (20) begin
      x = 4'($urandom);
      y = ($urandom_range(0, 2) == 0) ? x : 4'($urandom);
      start1 = 1'b1;
      a1 = x;
      b1 = y;
      @(negedge clk);
      start1 = 1'b0;
      chk("n1_rbusy", {busy1, done1}, 2'b10);
      @(negedge clk);
      chk("n1_rdone", {busy1, done1}, 2'b11);
      chk("n1_rflags", {lt1, gt1, eq1}, {x < y, x > y, x == y});
      @(negedge clk);
      chk("n1_ridle", {busy1, done1}, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
